// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer with in-order multi-lane retire, store-queue stall gating and mispredict flush.
// Define ROB_PERF_CNT_EN to add saturating perf_retired/perf_flushes counters.
module rob_param #(
  parameter int DEPTH  = 32,
  parameter int DISP_W = 3,
  parameter int CMPL_W = 3,
  parameter int RET_W  = 3,
  parameter int XLEN   = 32,
  parameter int PREG_W = 6,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DISP_W-1:0]        dispatch_valid,
  input  logic [DISP_W*XLEN-1:0]   dispatch_pc,
  input  logic [DISP_W*PREG_W-1:0] dispatch_tnew,
  input  logic [DISP_W*PREG_W-1:0] dispatch_told,
  input  logic [DISP_W-1:0]        dispatch_is_store,
  output logic [DISP_W*IDX_W-1:0]  dispatch_idx,
  output logic [IDX_W:0]           free_slots,
  input  logic [CMPL_W-1:0]        cmpl_valid,
  input  logic [CMPL_W*IDX_W-1:0]  cmpl_idx,
  input  logic [CMPL_W-1:0]        cmpl_mispredict,
  input  logic [CMPL_W*XLEN-1:0]   cmpl_target,
  input  logic                     sq_stall,
  output logic [RET_W-1:0]         retire_valid,
  output logic [RET_W*XLEN-1:0]    retire_pc,
  output logic [RET_W*PREG_W-1:0]  retire_tnew,
  output logic [RET_W*PREG_W-1:0]  retire_told,
  output logic                     recover_valid,
`ifdef ROB_PERF_CNT_EN
  output logic [31:0]              perf_retired,
  output logic [15:0]              perf_flushes,
`endif
  output logic [XLEN-1:0]          recover_pc
);
  logic [IDX_W:0] head_q, head_d, tail_q, tail_d, count, n_ret, n_disp;
  logic [DEPTH-1:0] valid_q, valid_d, comp_q, comp_d, misp_q, misp_d, store_q, store_d;
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [XLEN-1:0] pc_d [DEPTH];
  logic [XLEN-1:0] tgt_q [DEPTH];
  logic [XLEN-1:0] tgt_d [DEPTH];
  logic [PREG_W-1:0] tnew_q [DEPTH];
  logic [PREG_W-1:0] tnew_d [DEPTH];
  logic [PREG_W-1:0] told_q [DEPTH];
  logic [PREG_W-1:0] told_d [DEPTH];
  logic [IDX_W-1:0] disp_idx [DISP_W];
  logic [IDX_W-1:0] ret_idx [RET_W];
  logic [IDX_W-1:0] c_idx;
  logic go;

  assign count = tail_q - head_q;
  assign free_slots = (IDX_W+1)'(DEPTH) - count;

  always_comb begin
    dispatch_idx = '0;
    for (int i = 0; i < DISP_W; i++) begin
      disp_idx[i] = tail_q[IDX_W-1:0] + IDX_W'(i);
      dispatch_idx[i*IDX_W +: IDX_W] = disp_idx[i];
    end
    for (int k = 0; k < RET_W; k++)
      ret_idx[k] = head_q[IDX_W-1:0] + IDX_W'(k);
  end

  // Retire walks from head; the first ineligible lane or a retired mispredict closes the group.
  always_comb begin
    retire_valid = '0;
    retire_pc = '0;
    retire_tnew = '0;
    retire_told = '0;
    recover_valid = 1'b0;
    recover_pc = '0;
    n_ret = '0;
    go = 1'b1;
    for (int k = 0; k < RET_W; k++) begin
      go = go && !recover_valid && ((IDX_W+1)'(k) < count) && valid_q[ret_idx[k]] &&
           comp_q[ret_idx[k]] && !(store_q[ret_idx[k]] && sq_stall);
      if (go) begin
        retire_valid[k] = 1'b1;
        retire_pc[k*XLEN +: XLEN] = pc_q[ret_idx[k]];
        retire_tnew[k*PREG_W +: PREG_W] = tnew_q[ret_idx[k]];
        retire_told[k*PREG_W +: PREG_W] = told_q[ret_idx[k]];
        n_ret = n_ret + (IDX_W+1)'(1);
        if (misp_q[ret_idx[k]]) begin
          recover_valid = 1'b1;
          recover_pc = tgt_q[ret_idx[k]];
        end
      end
    end
  end

  always_comb begin
    head_d = head_q + n_ret;
    tail_d = tail_q;
    valid_d = valid_q;
    comp_d = comp_q;
    misp_d = misp_q;
    store_d = store_q;
    pc_d = pc_q;
    tgt_d = tgt_q;
    tnew_d = tnew_q;
    told_d = told_q;
    n_disp = '0;
    c_idx = '0;
    for (int k = 0; k < RET_W; k++)
      if (retire_valid[k]) valid_d[ret_idx[k]] = 1'b0;
    if (recover_valid) begin
      valid_d = '0;
      comp_d = '0;
      misp_d = '0;
      tail_d = head_d;
    end else begin
      for (int j = 0; j < CMPL_W; j++) begin
        c_idx = cmpl_idx[j*IDX_W +: IDX_W];
        if (cmpl_valid[j] && valid_q[c_idx]) begin
          comp_d[c_idx] = 1'b1;
          misp_d[c_idx] = cmpl_mispredict[j];
          tgt_d[c_idx] = cmpl_target[j*XLEN +: XLEN];
        end
      end
      // Dispatch only targets slots invalid in registered state, so it never collides with completion or retire.
      for (int i = 0; i < DISP_W; i++)
        if (dispatch_valid[i] && ((IDX_W+1)'(i) < free_slots)) begin
          valid_d[disp_idx[i]] = 1'b1;
          comp_d[disp_idx[i]] = 1'b0;
          misp_d[disp_idx[i]] = 1'b0;
          store_d[disp_idx[i]] = dispatch_is_store[i];
          pc_d[disp_idx[i]] = dispatch_pc[i*XLEN +: XLEN];
          tnew_d[disp_idx[i]] = dispatch_tnew[i*PREG_W +: PREG_W];
          told_d[disp_idx[i]] = dispatch_told[i*PREG_W +: PREG_W];
          n_disp = n_disp + (IDX_W+1)'(1);
        end
      tail_d = tail_q + n_disp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      valid_q <= '0;
      comp_q <= '0;
      misp_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      valid_q <= valid_d;
      comp_q <= comp_d;
      misp_q <= misp_d;
    end
    store_q <= store_d;
    pc_q <= pc_d;
    tgt_q <= tgt_d;
    tnew_q <= tnew_d;
    told_q <= told_d;
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_retired_q, perf_retired_d;
  logic [15:0] perf_flushes_q, perf_flushes_d;

  always_comb begin
    perf_retired_d = (32'hFFFF_FFFF - perf_retired_q < 32'(n_ret)) ? '1 : perf_retired_q + 32'(n_ret);
    perf_flushes_d = (recover_valid && perf_flushes_q != '1) ? perf_flushes_q + 16'd1 : perf_flushes_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_retired_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_flushes = perf_flushes_q;
`endif
endmodule
